// File: rtl/vga_timing_detector.sv
// vga_timing_detector: measures incoming active-low VGA sync geometry,
// regenerates pixel/line counters and tracks timing lock.
module vga_timing_detector #(
  parameter int CNT_W       = 16,
  parameter int MAX_H       = 4095,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             hSync,
  input  logic             vSync,
  output logic [CNT_W-1:0] hPixel,
  output logic [CNT_W-1:0] line,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_pulse,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_pulse,
  output logic             locked,
  output logic             frame_start,
  output logic             timing_error
);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_HV = CNT_W'(MAX_H);
  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + ONE;
  endfunction

  logic             hs_prev;
  logic             vs_prev;
  logic             hs_fall;
  logic             hs_rise;
  logic             vs_fall;
  logic             vs_rise;
  logic [CNT_W-1:0] h_cand;
  logic [CNT_W-1:0] v_cand;
  logic [CNT_W-1:0] hl_cnt;
  logic [CNT_W-1:0] vl_cnt;
  logic             to_seen;
  logic             timeout;

  logic [CNT_W-1:0] h_ref;
  logic             have_ref;
  logic             frame_bad;
  logic             frame_bad_now;
  logic [CNT_W-1:0] h_ref_now;

  state_t           state;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] h_prev;
  logic [CNT_W-1:0] v_prev;
  logic             meas_same;
  logic [CNT_W-1:0] meas_next;
  logic             lock_err;

  assign hs_fall = hs_prev & ~hSync;
  assign hs_rise = ~hs_prev & hSync;
  assign vs_fall = vs_prev & ~vSync;
  assign vs_rise = ~vs_prev & vSync;

  assign h_cand = sat_inc(hPixel);
  assign v_cand = sat_inc(line);

  assign timeout = (hPixel == MAX_HV) & ~hs_fall & ~to_seen;

  // A line ending on the closing vs_fall still belongs to that frame
  assign frame_bad_now = frame_bad |
    (hs_fall & have_ref & (h_cand != h_ref));
  assign h_ref_now = (!have_ref && hs_fall) ? h_cand : h_ref;

  assign meas_same = (match_cnt != '0) &&
    (h_ref_now == h_prev) && (v_cand == v_prev);
  assign meas_next = frame_bad_now ? '0 :
    (meas_same ? match_cnt + ONE : ONE);

  assign lock_err = (hs_fall & (h_cand != h_prev)) |
    (vs_fall & (v_cand != v_prev));

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      hPixel      <= '0;
      line        <= '0;
      h_total     <= '0;
      v_total     <= '0;
      hl_cnt      <= '0;
      vl_cnt      <= '0;
      h_pulse     <= '0;
      v_pulse     <= '0;
      frame_start <= 1'b0;
      to_seen     <= 1'b0;
    end else begin
      hs_prev     <= hSync;
      vs_prev     <= vSync;
      frame_start <= vs_fall;

      if (hs_fall) begin
        hPixel  <= '0;
        h_total <= h_cand;
      end else begin
        hPixel <= sat_inc(hPixel);
      end

      if (vs_fall) begin
        line    <= '0;
        v_total <= v_cand;
      end else if (hs_fall) begin
        line <= sat_inc(line);
      end

      if (hs_fall) begin
        hl_cnt <= '0;
      end else if (!hSync) begin
        hl_cnt <= sat_inc(hl_cnt);
      end
      if (hs_rise) begin
        h_pulse <= sat_inc(hl_cnt);
      end

      // Lines are counted by the hSync edges sampled while vSync is low
      if (vs_fall) begin
        vl_cnt <= hs_fall ? ONE : '0;
      end else if (!vSync && hs_fall) begin
        vl_cnt <= sat_inc(vl_cnt);
      end
      if (vs_rise) begin
        v_pulse <= vl_cnt;
      end

      if (hs_fall) begin
        to_seen <= 1'b0;
      end else if (timeout) begin
        to_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      h_ref     <= '0;
      have_ref  <= 1'b0;
      frame_bad <= 1'b0;
    end else if (vs_fall) begin
      have_ref  <= 1'b0;
      frame_bad <= 1'b0;
    end else if (hs_fall) begin
      if (!have_ref) begin
        h_ref    <= h_cand;
        have_ref <= 1'b1;
      end else if (h_cand != h_ref) begin
        frame_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state        <= SEARCH;
      match_cnt    <= '0;
      h_prev       <= '0;
      v_prev       <= '0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      timing_error <= 1'b0;
      if (timeout) begin
        state        <= SEARCH;
        match_cnt    <= '0;
        locked       <= 1'b0;
        timing_error <= 1'b1;
      end else begin
        unique case (state)
          SEARCH: begin
            if (vs_fall) begin
              state     <= MEASURE;
              match_cnt <= '0;
            end
          end
          MEASURE: begin
            if (vs_fall) begin
              match_cnt <= meas_next;
              h_prev    <= h_ref_now;
              v_prev    <= v_cand;
              if (meas_next == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (lock_err) begin
              state        <= MEASURE;
              match_cnt    <= '0;
              locked       <= 1'b0;
              timing_error <= 1'b1;
            end
          end
          default: begin
            state     <= SEARCH;
            match_cnt <= '0;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/vga_timing_detector.md
# vga_timing_detector

Receive-side counterpart of the video timing controller: consumes active-low hSync/vSync in the pixel clock domain, measures line and frame geometry, and regenerates sync-aligned pixel/line counters. A lock state machine declares the timing stable after consecutive identical frames and flags any later deviation. It sits at the input of downstream capture/overlay logic that must follow an external or looped-back VGA timing stream.

## Interface
- CNT_W, 16, width of all counters and measurement outputs
- MAX_H, 4095, clocks without an hSync falling edge before timeout; must be < 2^CNT_W − 1
- LOCK_FRAMES, 2, consecutive identical complete frames required to lock (≥ 1)

- clock_in  input  1  pixel clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- hSync  input  1  horizontal sync, active low, synchronous to clock_in
- vSync  input  1  vertical sync, active low, synchronous to clock_in
- hPixel  output  CNT_W  clocks since last hSync falling edge
- line  output  CNT_W  hSync falling edges since last vSync falling edge
- h_total  output  CNT_W  last captured line period, clocks
- h_pulse  output  CNT_W  last captured hSync low width, clocks
- v_total  output  CNT_W  last captured frame period, lines
- v_pulse  output  CNT_W  last captured vSync low width, lines
- locked  output  1  timing stable
- frame_start  output  1  one-cycle pulse per vSync falling edge
- timing_error  output  1  one-cycle pulse on lock loss or timeout

## Operation
- Edge detect: hs_prev/vs_prev registers (reset 1). hs_fall = hs_prev & ~hSync; hs_rise = ~hs_prev & hSync; same for vSync.
- hPixel: 0 on the edge where hs_fall; else +1, saturating at all-ones. Capture period h_cand = hPixel + 1 on hs_fall.
- h_pulse: low-width counter cleared on hs_fall, +1 while low; h_pulse <= count + 1 on hs_rise.
- line: +1 on hs_fall (saturating); 0 on vs_fall. vs_fall and hs_fall same cycle: vs_fall wins, line = 0, v_cand = line + 1.
- v_pulse: hs_fall count while vSync low, published on vs_rise.
- h_total <= h_cand on every hs_fall; v_total <= v_cand on every vs_fall.
- Per-frame check: first h_cand of a frame becomes h_ref; any later h_cand ≠ h_ref sets frame_bad. Both cleared on vs_fall.
- States:
  - SEARCH (reset state): on vs_fall → MEASURE, match_cnt = 0 (partial frame discarded).
  - MEASURE: on vs_fall, if !frame_bad and match_cnt > 0 and (h_ref, v_cand) == (h_prev, v_prev) → match_cnt + 1; else match_cnt = 1 if !frame_bad, 0 otherwise. Store h_prev/v_prev. When new match_cnt == LOCK_FRAMES → LOCKED.
  - LOCKED: hs_fall with h_cand ≠ h_prev, or vs_fall with v_cand ≠ v_prev → timing_error, MEASURE, match_cnt = 0.
- Timeout (any state): hPixel == MAX_H with no hs_fall → timing_error, SEARCH, match_cnt 0. Only one pulse per timeout episode (hold until next hs_fall).
- locked = (state == LOCKED), registered.

## Timing
- All outputs registered; reset value 0 for every output and counter, state SEARCH.
- Reset asserted mid-frame: immediate clear; full relock required after release.
- hPixel/line/h_total/v_total update on the clock edge that samples the sync edge.
- frame_start: high the cycle after the vs_fall sample edge, exactly one cycle.
- locked rises/falls the cycle after the deciding vs_fall/hs_fall/timeout edge; timing_error pulses in that same cycle.
- Lock latency with clean input: first vs_fall + LOCK_FRAMES complete frames.

## Test plan
- Synthetic stream h_total 20, hSync low 3, v_total 10, vSync low 2 lines → after 1 partial + 2 full frames locked = 1; h_total 20, h_pulse 3, v_total 10, v_pulse 2; frame_start once per frame.
- Locked, one line shortened to 19 clocks → timing_error single pulse, locked 0 next cycle, relocks after 2 clean frames.
- Locked, frame shortened to 9 lines → error at that vs_fall, h_total still 20, v_total 9.
- hSync held high > MAX_H (set 50) → single timing_error, state SEARCH, hPixel saturates not wraps; resume → relock.
- vSync and hSync falling in the same clock → line = 0, v_total counts correctly, no error.
- Reset asserted mid-frame while locked → all outputs 0 immediately; standard 800×525 (hsync 96, vsync 2) stream then locks with h_total 800, v_total 525.
